// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared state encoding, default sizes and address-width helper for the layer feeder
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_e;

  localparam int DEF_DW  = 8;
  localparam int DEF_N   = 10;
  localparam int DEF_M   = 21;
  localparam int DEF_TMO = 64;

  // A depth of one still needs a one-bit address port.
  function automatic int aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ann_layer_feeder_if.sv
// rtl/ann_layer_feeder_if.sv - operand/result bus between the layer feeder and one ANN core
interface ann_layer_feeder_if #(
  parameter int DW = 8
);

  logic [DW-1:0] ann_value;
  logic [DW-1:0] ann_weight;
  logic [DW-1:0] ann_bias;
  logic          ann_start;
  logic          ann_hidden;
  logic [DW-1:0] ann_result;
  logic          ann_ready;

  modport master (
    output ann_value, ann_weight, ann_bias, ann_start, ann_hidden,
    input  ann_result, ann_ready
  );

  modport slave (
    input  ann_value, ann_weight, ann_bias, ann_start, ann_hidden,
    output ann_result, ann_ready
  );

endinterface

// File: rtl/ann_watchdog.sv
// rtl/ann_watchdog.sv - cycle watchdog; expires on the TMO-th consecutive counted cycle
module ann_watchdog
  import ann_pkg::*;
#(
  parameter int TMO = DEF_TMO
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = aw(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = count && (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && !expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ann_layer_feeder.sv
// rtl/ann_layer_feeder.sv - walks M neurons, streams N operand pairs each into an ANN core, stores results
// ANN_TIMEOUT_EN adds a WAIT-state watchdog that aborts the layer and raises err.
module ann_layer_feeder
  import ann_pkg::*;
#(
  parameter int  DW  = DEF_DW,
  parameter int  N   = DEF_N,
  parameter int  M   = DEF_M,
  parameter int  TMO = DEF_TMO,
  localparam int VAW = aw(N),
  localparam int WAW = aw(N * M),
  localparam int BAW = aw(M)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      cfg_hidden,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [VAW-1:0]            val_addr,
  input  logic [DW-1:0]             val_rdata,
  output logic [WAW-1:0]            wgt_addr,
  input  logic [DW-1:0]             wgt_rdata,
  output logic [BAW-1:0]            bias_addr,
  input  logic [DW-1:0]             bias_rdata,
  ann_layer_feeder_if.master        ann,
  output logic                      res_we,
  output logic [BAW-1:0]            res_addr,
  output logic [DW-1:0]             res_data
);

  state_e         state_q, state_d;
  logic [VAW-1:0] i_q, i_d;
  logic [BAW-1:0] j_q, j_d;
  logic [VAW-1:0] val_addr_q, val_addr_d;
  logic [WAW-1:0] wgt_addr_q, wgt_addr_d;
  logic           hidden_q, hidden_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic           feed;

`ifdef ANN_TIMEOUT_EN
  logic err_q, err_d, timeout;

  ann_watchdog #(.TMO(TMO)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q != ST_WAIT),
    .count  (state_q == ST_WAIT),
    .expire (timeout)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign feed           = (state_q == ST_FEED);
  assign busy           = (state_q == ST_START) || (state_q == ST_FEED) ||
                          (state_q == ST_WAIT)  || (state_q == ST_STORE);
  assign done           = (state_q == ST_DONE);
  assign ann.ann_start  = (state_q == ST_START);
  assign ann.ann_hidden = hidden_q;
  assign ann.ann_value  = feed ? val_rdata  : '0;
  assign ann.ann_weight = feed ? wgt_rdata  : '0;
  assign ann.ann_bias   = feed ? bias_rdata : '0;
  assign val_addr       = val_addr_q;
  assign wgt_addr       = wgt_addr_q;
  assign bias_addr      = j_q;
  assign res_we         = (state_q == ST_STORE);
  assign res_addr       = j_q;
  assign res_data       = res_data_q;

  // Addresses are issued one cycle ahead of the operand they fetch; the last FEED issues nothing.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    val_addr_d = val_addr_q;
    wgt_addr_d = wgt_addr_q;
    hidden_d   = hidden_q;
    res_data_d = res_data_q;
`ifdef ANN_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d    = ST_START;
          i_d        = '0;
          j_d        = '0;
          val_addr_d = '0;
          wgt_addr_d = '0;
          hidden_d   = cfg_hidden;
`ifdef ANN_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      ST_START: begin
        state_d    = ST_FEED;
        i_d        = '0;
        val_addr_d = val_addr_q + VAW'(1);
        wgt_addr_d = wgt_addr_q + WAW'(1);
      end
      ST_FEED: begin
        if (i_q == VAW'(N - 1)) begin
          state_d    = ST_WAIT;
          val_addr_d = '0;
        end else begin
          i_d = i_q + VAW'(1);
          if (i_q < VAW'(N - 2)) begin
            val_addr_d = val_addr_q + VAW'(1);
            wgt_addr_d = wgt_addr_q + WAW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (ann.ann_ready) begin
          state_d    = ST_STORE;
          res_data_d = ann.ann_result;
        end
`ifdef ANN_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_STORE: begin
        if (j_q == BAW'(M - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_START;
          j_d        = j_q + BAW'(1);
          wgt_addr_d = wgt_addr_q + WAW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      val_addr_q <= '0;
      wgt_addr_q <= '0;
      hidden_q   <= 1'b0;
      res_data_q <= '0;
`ifdef ANN_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      val_addr_q <= val_addr_d;
      wgt_addr_q <= wgt_addr_d;
      hidden_q   <= hidden_d;
      res_data_q <= res_data_d;
`ifdef ANN_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ann_layer_feeder.sv
// tb/tb_ann_layer_feeder.sv - directed/randomized self-checking bench for ann_layer_feeder
module tb_ann_layer_feeder;

  localparam int DW  = 8;
  localparam int N   = 10;
  localparam int M   = 3;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       cfg_hidden = 1'b0;
  logic       busy, done, err;
  logic [3:0] val_addr;
  logic [4:0] wgt_addr;
  logic [1:0] bias_addr;
  logic [DW-1:0] val_rdata, wgt_rdata, bias_rdata;
  logic       res_we;
  logic [1:0] res_addr;
  logic [DW-1:0] res_data;

  logic [DW-1:0] val_mem [N];
  logic [DW-1:0] wgt_mem [N*M];
  logic [DW-1:0] bias_mem [M];

  int vectors = 0;
  int miscompares = 0;

  ann_layer_feeder_if #(.DW(DW)) ann_bus ();

  ann_layer_feeder #(.DW(DW), .N(N), .M(M), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .cfg_hidden (cfg_hidden),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .val_addr   (val_addr),
    .val_rdata  (val_rdata),
    .wgt_addr   (wgt_addr),
    .wgt_rdata  (wgt_rdata),
    .bias_addr  (bias_addr),
    .bias_rdata (bias_rdata),
    .ann        (ann_bus),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data)
  );

  always #5 clk = ~clk;

  // Layer memories with one cycle of read latency.
  always @(posedge clk) begin
    val_rdata  <= val_mem[val_addr];
    wgt_rdata  <= wgt_mem[wgt_addr];
    bias_rdata <= bias_mem[bias_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_addrs"}, {val_addr, wgt_addr, bias_addr}, 0);
    chk({tag, "_ops"}, {ann_bus.ann_value, ann_bus.ann_weight, ann_bus.ann_bias}, 0);
    chk({tag, "_start_hid"}, {ann_bus.ann_start, ann_bus.ann_hidden}, 0);
    chk({tag, "_res"}, {res_we, res_addr, res_data}, 0);
  endtask

  // One layer as seen from the ANN side. abort_j/tmo_j select the neuron that is
  // reset mid-FEED or left without ready (-1 disables).
  task automatic run_layer(input int dly, input bit hold_go, input bit glitch,
                           input int abort_j, input int tmo_j, input bit hid);
    int d;
    logic [DW-1:0] r;
    foreach (val_mem[a])  val_mem[a]  = DW'($urandom);
    foreach (wgt_mem[a])  wgt_mem[a]  = DW'($urandom);
    foreach (bias_mem[a]) bias_mem[a] = DW'($urandom);
    cfg_hidden = hid;
    go = 1'b1;
    step();
    if (!hold_go) go = 1'b0;
    chk("err_clear_on_go", err, 0);
    for (int j = 0; j < M; j++) begin
      chk("start_pulse", ann_bus.ann_start, 1);
      chk("busy_start", busy, 1);
      chk("val_addr_start", val_addr, 0);
      chk("wgt_addr_start", wgt_addr, j * N);
      chk("bias_addr", bias_addr, j);
      chk("hidden", ann_bus.ann_hidden, hid);
      for (int k = 0; k < N; k++) begin
        step();
        chk("start_low_feed", ann_bus.ann_start, 0);
        chk("ann_value", ann_bus.ann_value, val_mem[k]);
        chk("ann_weight", ann_bus.ann_weight, wgt_mem[j*N+k]);
        chk("ann_bias", ann_bus.ann_bias, bias_mem[j]);
        chk("no_we_feed", res_we, 0);
        if (k < N - 1) begin
          chk("val_addr_feed", val_addr, k + 1);
          chk("wgt_addr_feed", wgt_addr, j * N + k + 1);
        end
        ann_bus.ann_ready  = (glitch && j == 0 && k == 3);
        ann_bus.ann_result = 8'hFF;
        if (j == abort_j && k == 2) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          chk_zero("abort");
          step();
          step();
          chk("abort_no_done", {done, busy, res_we, ann_bus.ann_start}, 0);
          return;
        end
      end
      step();
      if (j == tmo_j) begin
        for (int w = 1; w <= TMO; w++) begin
          chk("tmo_wait", {busy, done, res_we}, 3'b100);
          step();
        end
        chk("tmo_done", {busy, done, err, res_we}, 4'b0110);
        step();
        chk("tmo_idle", {busy, done, err}, 3'b001);
        return;
      end
      d = (glitch && j == 0) ? 1 : (dly > 0) ? dly : int'($urandom_range(1, 6));
      r = (j == 1) ? 8'hA5 : DW'($urandom);
      for (int w = 1; w <= d; w++) begin
        chk("wait_no_we", res_we, 0);
        chk("wait_ops_gated", {ann_bus.ann_value, ann_bus.ann_weight, ann_bus.ann_bias}, 0);
        if (w == d) begin
          ann_bus.ann_ready  = 1'b1;
          ann_bus.ann_result = r;
        end
        step();
      end
      ann_bus.ann_ready  = 1'b0;
      ann_bus.ann_result = ~r;
      chk("store_we", res_we, 1);
      chk("store_addr", res_addr, j);
      chk("store_data", res_data, r);
      step();
    end
    chk("done_pulse", {done, busy}, 2'b10);
    go = 1'b0;
    step();
    chk("idle_after_done", {done, busy, ann_bus.ann_start}, 0);
    if (hold_go) begin
      step();
      chk("no_restart", {busy, ann_bus.ann_start}, 0);
    end
  endtask

  initial begin
    ann_bus.ann_ready  = 1'b0;
    ann_bus.ann_result = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_zero("reset");
    step();
    chk("idle_no_go", busy, 0);

    run_layer(0, 1'b0, 1'b0, -1, -1, 1'b1);
    run_layer(5, 1'b0, 1'b0, -1, -1, 1'b0);
    run_layer(0, 1'b1, 1'b0, -1, -1, 1'b1);
    run_layer(0, 1'b0, 1'b0, -1, -1, 1'b0);
    run_layer(0, 1'b0, 1'b0, 1, -1, 1'b1);
    run_layer(0, 1'b0, 1'b0, -1, -1, 1'b0);
    run_layer(0, 1'b0, 1'b1, -1, -1, 1'b0);
`ifdef ANN_TIMEOUT_EN
    run_layer(0, 1'b0, 1'b0, -1, 2, 1'b0);
    run_layer(0, 1'b0, 1'b0, -1, -1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
